// File: rtl/grid_stream_pkg.sv
// Shared types and default extents for the bit-grid reader.
// Optional row parity is built when GRID_STREAM_PARITY_EN is defined.
package grid_stream_pkg;

    localparam int unsigned GRID_W  = 16;
    localparam int unsigned GRID_H  = 16;
    localparam int unsigned GRID_AW = 4;
    localparam int unsigned GRID_AH = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        PARITY,
        DONE
    } grid_stream_state_t;

endpackage

// File: rtl/grid_bit_streamer_addr_gen.sv
// Raster x/y cell counter: x inner, y outer, wrapping at the grid extents
// rather than at the address-width limit.
module grid_addr_gen
    import grid_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = GRID_W,
    parameter int unsigned HEIGHT = GRID_H,
    parameter int unsigned ADDR_W = GRID_AW,
    parameter int unsigned ADDR_H = GRID_AH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_H-1:0] y,
    output logic              last_x,
    output logic              last_y
);

    assign last_x = (x == ADDR_W'(WIDTH - 1));
    assign last_y = (y == ADDR_H'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_x) begin
                x <= '0;
                y <= last_y ? '0 : y + ADDR_H'(1);
            end else begin
                x <= x + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/grid_bit_streamer.sv
// Walks a WIDTH x HEIGHT single-bit memory and streams each cell with
// sof/eol/eof markers. Define GRID_STREAM_PARITY_EN for a per-row parity beat.
module grid_bit_streamer
    import grid_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = GRID_W,
    parameter int unsigned HEIGHT = GRID_H,
    parameter int unsigned ADDR_W = GRID_AW,
    parameter int unsigned ADDR_H = GRID_AH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr_x,
    output logic [ADDR_H-1:0] mem_addr_y,
    input  logic              mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof
);

    grid_stream_state_t state_q, state_d;
    logic clr, adv, last_x, last_y;

    grid_addr_gen #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W),
        .ADDR_H(ADDR_H)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (clr),
        .advance(adv),
        .x      (mem_addr_x),
        .y      (mem_addr_y),
        .last_x (last_x),
        .last_y (last_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        adv       = 1'b0;
        mem_rd    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                clr  = 1'b1;
                if (start) state_d = FETCH;
            end
            FETCH: begin
                mem_rd  = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef GRID_STREAM_PARITY_EN
                    if (last_x) begin
                        state_d = PARITY;
                    end else begin
                        adv     = 1'b1;
                        state_d = FETCH;
                    end
`else
                    if (last_x && last_y) begin
                        state_d = DONE;
                    end else begin
                        adv     = 1'b1;
                        state_d = FETCH;
                    end
`endif
                end
            end
`ifdef GRID_STREAM_PARITY_EN
            PARITY: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_y) begin
                        state_d = DONE;
                    end else begin
                        adv     = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef GRID_STREAM_PARITY_EN
    logic row_par;
`endif

    // Output beat register: loaded in FETCH, and with the row parity on the
    // last data handshake of a row; otherwise held so stalls are lossless.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bit <= 1'b0;
            out_sof <= 1'b0;
            out_eol <= 1'b0;
            out_eof <= 1'b0;
`ifdef GRID_STREAM_PARITY_EN
            row_par <= 1'b0;
`endif
        end else if (state_q == FETCH) begin
            out_bit <= mem_data;
            out_sof <= (mem_addr_x == '0) && (mem_addr_y == '0);
`ifdef GRID_STREAM_PARITY_EN
            out_eol <= 1'b0;
            out_eof <= 1'b0;
            row_par <= (mem_addr_x == '0) ? mem_data : (row_par ^ mem_data);
`else
            out_eol <= last_x;
            out_eof <= last_x && last_y;
`endif
        end
`ifdef GRID_STREAM_PARITY_EN
        else if (state_q == SEND && out_ready && last_x) begin
            out_bit <= row_par;
            out_sof <= 1'b0;
            out_eol <= 1'b1;
            out_eof <= last_y;
        end
`endif
    end

endmodule
